// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiply sequencer.
package mm_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StMac   = 3'd2,
    StDrain = 3'd3,
    StStore = 3'd4,
    StDone  = 3'd5
  } mm_state_e;

  localparam int unsigned DefRows   = 2;
  localparam int unsigned DefCols   = 2;
  localparam int unsigned DefInner  = 2;
  localparam int unsigned DefMacLat = 1;

  // Index width able to hold max(rows, cols, inner) - 1, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned rows, input int unsigned cols,
                                            input int unsigned inner);
    int unsigned m;
    m = rows;
    if (cols > m) m = cols;
    if (inner > m) m = inner;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mm_index_counter.sv
// Nested k / column / row counter walking C in row-major order.
module mm_index_counter #(
  parameter int unsigned ROWS  = 2,
  parameter int unsigned COLS  = 2,
  parameter int unsigned INNER = 2,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             k_inc_i,
  input  logic             elem_inc_i,
  output logic [IDX_W-1:0] row_o,
  output logic [IDX_W-1:0] col_o,
  output logic [IDX_W-1:0] k_o,
  output logic             k_last_o,
  output logic             elem_last_o
);

  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             row_last, col_last;

  assign row_last    = (row_q == IDX_W'(ROWS - 1));
  assign col_last    = (col_q == IDX_W'(COLS - 1));
  assign k_last_o    = (k_q == IDX_W'(INNER - 1));
  assign elem_last_o = row_last && col_last;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    k_d   = k_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
      k_d   = '0;
    end else begin
      if (k_inc_i) begin
        k_d = k_last_o ? '0 : k_q + IDX_W'(1);
      end
      if (elem_inc_i) begin
        if (col_last) begin
          col_d = '0;
          row_d = row_last ? '0 : row_q + IDX_W'(1);
        end else begin
          col_d = col_q + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
      k_q   <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      k_q   <= k_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;
  assign k_o   = k_q;

endmodule

// File: rtl/mm_sequencer.sv
// Control sequencer for the matrix-multiply datapath: clear, accumulate INNER products,
// drain the MAC pipeline, then store, for each element of C in row-major order.
module mm_sequencer
  import mm_pkg::*;
#(
  parameter int unsigned ROWS    = DefRows,
  parameter int unsigned COLS    = DefCols,
  parameter int unsigned INNER   = DefInner,
  parameter int unsigned MAC_LAT = DefMacLat,
  parameter int unsigned IDX_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             operand_valid_i,
  output logic [IDX_W-1:0] row_idx_o,
  output logic [IDX_W-1:0] col_idx_o,
  output logic [IDX_W-1:0] k_idx_o,
  output logic             load_operands_o,
  output logic             mac_clear_o,
  output logic             mac_enable_o,
  output logic             store_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned DrainW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  mm_state_e         state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              cnt_clear, k_inc, elem_inc;
  logic              k_last, elem_last, drain_last;

  assign drain_last = (32'(drain_q) == MAC_LAT - 1);

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    cnt_clear = 1'b0;
    k_inc     = 1'b0;
    elem_inc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StClear;
          cnt_clear = 1'b1;
        end
      end
      StClear: state_d = StMac;
      StMac: begin
        if (operand_valid_i) begin
          k_inc = 1'b1;
          if (k_last) begin
            state_d = (MAC_LAT == 0) ? StStore : StDrain;
            drain_d = '0;
          end
        end
      end
      StDrain: begin
        if (drain_last) state_d = StStore;
        else            drain_d = drain_q + DrainW'(1);
      end
      StStore: begin
        elem_inc = 1'b1;
        state_d  = elem_last ? StDone : StClear;
      end
      StDone: state_d = StIdle;
      default: begin
        state_d   = StIdle;
        cnt_clear = 1'b1;
      end
    endcase
    // Abort overrides every transition except in IDLE, where start alone decides.
    if (abort_i && (state_q != StIdle)) begin
      state_d   = StIdle;
      drain_d   = '0;
      cnt_clear = 1'b1;
      k_inc     = 1'b0;
      elem_inc  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  mm_index_counter #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .INNER (INNER),
    .IDX_W (IDX_W)
  ) u_index (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (cnt_clear),
    .k_inc_i     (k_inc),
    .elem_inc_i  (elem_inc),
    .row_o       (row_idx_o),
    .col_o       (col_idx_o),
    .k_o         (k_idx_o),
    .k_last_o    (k_last),
    .elem_last_o (elem_last)
  );

  assign busy_o          = (state_q != StIdle);
  assign mac_clear_o     = (state_q == StClear);
  assign load_operands_o = (state_q == StMac);
  // operand_valid qualifies the accumulate in the same cycle the operands are presented.
  assign mac_enable_o    = (state_q == StMac) && operand_valid_i;
  assign store_o         = (state_q == StStore);
  assign done_o          = (state_q == StDone);

endmodule

// File: tb/tb_mm_sequencer.sv
// Self-checking bench for mm_sequencer against a cycle-schedule model built from the
// element/product/drain timing rules.
module tb_mm_sequencer;
  import mm_pkg::*;

  localparam int          MAXC = 256;
  localparam int unsigned W1   = idx_width(3, 1, 4);

  typedef struct packed {
    logic busy;
    logic clr;
    logic load;
    logic mac;
    logic store;
    logic done;
  } sig_t;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] k;
  } idx_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic operand_valid = 1'b0;
  logic sel = 1'b0;

  always #5 clock = ~clock;

  logic [3:0]    row0, col0, k0;
  logic [W1-1:0] row1, col1, k1;
  logic load0, clr0, mac0, store0, busy0, done0;
  logic load1, clr1, mac1, store1, busy1, done1;
  logic start0, start1, abort0, abort1;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign abort0 = abort & ~sel;
  assign abort1 = abort & sel;

  mm_sequencer u_dut0 (
    .clock           (clock),
    .reset           (reset),
    .start_i         (start0),
    .abort_i         (abort0),
    .operand_valid_i (operand_valid),
    .row_idx_o       (row0),
    .col_idx_o       (col0),
    .k_idx_o         (k0),
    .load_operands_o (load0),
    .mac_clear_o     (clr0),
    .mac_enable_o    (mac0),
    .store_o         (store0),
    .busy_o          (busy0),
    .done_o          (done0)
  );

  mm_sequencer #(
    .ROWS    (3),
    .COLS    (1),
    .INNER   (4),
    .MAC_LAT (0),
    .IDX_W   (W1)
  ) u_dut1 (
    .clock           (clock),
    .reset           (reset),
    .start_i         (start1),
    .abort_i         (abort1),
    .operand_valid_i (operand_valid),
    .row_idx_o       (row1),
    .col_idx_o       (col1),
    .k_idx_o         (k1),
    .load_operands_o (load1),
    .mac_clear_o     (clr1),
    .mac_enable_o    (mac1),
    .store_o         (store1),
    .busy_o          (busy1),
    .done_o          (done1)
  );

  sig_t obs_sig;
  idx_t obs_idx;

  assign obs_sig = sel ? {busy1, clr1, load1, mac1, store1, done1}
                       : {busy0, clr0, load0, mac0, store0, done0};
  assign obs_idx = sel ? {{(4 - W1){1'b0}}, row1, {(4 - W1){1'b0}}, col1, {(4 - W1){1'b0}}, k1}
                       : {row0, col0, k0};

  sig_t exp_sig[MAXC];
  idx_t exp_idx[MAXC];
  bit   exp_chk[MAXC];
  bit   vld[MAXC];
  bit   stv[MAXC];
  bit   abt[MAXC];
  int   done_c, last_c, drain01_c, stalls;
  int   total = 0;
  int   bad = 0;

  function automatic sig_t mk(input logic b, input logic cl, input logic l, input logic m,
                              input logic s, input logic d);
    return {b, cl, l, m, s, d};
  endfunction

  function automatic idx_t mki(input int i, input int j, input int k);
    return {4'(i), 4'(j), 4'(k)};
  endfunction

  task automatic put(input int c, input sig_t s, input int i, input int j, input int k);
    exp_sig[c] = s;
    exp_idx[c] = mki(i, j, k);
    exp_chk[c] = 1'b1;
  endtask

  // Expected per-cycle schedule of one run; cycle 1 is the cycle after the start edge.
  task automatic build(input int rows, input int cols, input int inner, input int lat);
    int c;
    for (int n = 0; n < MAXC; n++) begin
      exp_sig[n] = '0;
      exp_idx[n] = '0;
      exp_chk[n] = 1'b0;
      stv[n]     = 1'b0;
      abt[n]     = 1'b0;
    end
    c = 1;
    stalls = 0;
    drain01_c = 0;
    for (int i = 0; i < rows; i++) begin
      for (int j = 0; j < cols; j++) begin
        put(c, mk(1, 1, 0, 0, 0, 0), i, j, 0);
        c++;
        for (int k = 0; k < inner; k++) begin
          while (!vld[c] && c < MAXC - 8) begin
            put(c, mk(1, 0, 1, 0, 0, 0), i, j, k);
            c++;
            stalls++;
          end
          put(c, mk(1, 0, 1, 1, 0, 0), i, j, k);
          c++;
        end
        if (i == 0 && j == 1) drain01_c = c;
        for (int d = 0; d < lat; d++) begin
          put(c, mk(1, 0, 0, 0, 0, 0), i, j, 0);
          c++;
        end
        put(c, mk(1, 0, 0, 0, 1, 0), i, j, 0);
        c++;
      end
    end
    exp_sig[c] = mk(1, 0, 0, 0, 0, 1);
    done_c = c;
    last_c = c + 1;
  endtask

  task automatic truncate(input int ac);
    for (int n = ac + 1; n < MAXC; n++) begin
      exp_sig[n] = '0;
      exp_idx[n] = '0;
      exp_chk[n] = 1'b1;
    end
    abt[ac] = 1'b1;
    last_c = ac + 3;
  endtask

  task automatic step(input int c);
    @(posedge clock);
    #1;
    operand_valid = vld[c];
    start = stv[c];
    abort = abt[c];
    @(negedge clock);
  endtask

  task automatic all_valid();
    for (int n = 0; n < MAXC; n++) vld[n] = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      total++;
      if (obs_sig !== '0 || obs_idx !== '0) begin
        bad++;
        $display("FAIL reset_async dut=%0d got sig=%b idx=%h want 0", s, obs_sig, obs_idx);
      end
    end
    sel = 1'b0;
    @(negedge clock);
    @(negedge clock);
    total++;
    if (obs_sig !== '0 || obs_idx !== '0) begin
      bad++;
      $display("FAIL reset_held got sig=%b idx=%h want 0", obs_sig, obs_idx);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    int         first_done, macs;
    logic [7:0] st[$];
    logic [7:0] want[4];
    want = '{8'h00, 8'h01, 8'h10, 8'h11};
    sel = 1'b0;
    all_valid();
    build(2, 2, 2, 1);
    first_done = 0;
    macs = 0;
    start = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      step(c);
      total++;
      if (obs_sig !== exp_sig[c]) begin
        bad++;
        $display("FAIL basic_sig cyc=%0d got=%b want=%b", c, obs_sig, exp_sig[c]);
      end
      if (exp_chk[c]) begin
        total++;
        if (obs_idx !== exp_idx[c]) begin
          bad++;
          $display("FAIL basic_idx cyc=%0d got=%h want=%h", c, obs_idx, exp_idx[c]);
        end
      end
      if (obs_sig.mac) macs++;
      if (obs_sig.store) st.push_back({obs_idx.row, obs_idx.col});
      if (obs_sig.done && first_done == 0) first_done = c;
    end
    total++;
    if (macs != 8) begin
      bad++;
      $display("FAIL basic_mac_count got=%0d want=8", macs);
    end
    total++;
    if (first_done != 21) begin
      bad++;
      $display("FAIL basic_latency got=%0d want=21", first_done);
    end
    total++;
    if (st.size() != 4) begin
      bad++;
      $display("FAIL basic_store_count got=%0d want=4", st.size());
    end else begin
      for (int n = 0; n < 4; n++) begin
        total++;
        if (st[n] !== want[n]) begin
          bad++;
          $display("FAIL basic_store_order n=%0d got=%h want=%h", n, st[n], want[n]);
        end
      end
    end
  endtask

  task automatic test_dims();
    int first_done, drains, stores;
    sel = 1'b1;
    all_valid();
    build(3, 1, 4, 0);
    first_done = 0;
    drains = 0;
    stores = 0;
    start = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      step(c);
      total++;
      if (obs_sig !== exp_sig[c]) begin
        bad++;
        $display("FAIL dims_sig cyc=%0d got=%b want=%b", c, obs_sig, exp_sig[c]);
      end
      if (exp_chk[c]) begin
        total++;
        if (obs_idx !== exp_idx[c]) begin
          bad++;
          $display("FAIL dims_idx cyc=%0d got=%h want=%h", c, obs_idx, exp_idx[c]);
        end
      end
      if (obs_sig == mk(1, 0, 0, 0, 0, 0)) drains++;
      if (obs_sig.store) stores++;
      if (obs_sig.done && first_done == 0) first_done = c;
    end
    total++;
    if (first_done != 19 || drains != 0 || stores != 3) begin
      bad++;
      $display("FAIL dims_summary got done=%0d drains=%0d stores=%0d want 19/0/3",
               first_done, drains, stores);
    end
    sel = 1'b0;
  endtask

  task automatic test_stall();
    int first_done;
    sel = 1'b0;
    all_valid();
    vld[3] = 1'b0;
    vld[4] = 1'b0;
    vld[5] = 1'b0;
    build(2, 2, 2, 1);
    first_done = 0;
    start = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      step(c);
      total++;
      if (obs_sig !== exp_sig[c]) begin
        bad++;
        $display("FAIL stall_sig cyc=%0d got=%b want=%b", c, obs_sig, exp_sig[c]);
      end
      if (exp_chk[c]) begin
        total++;
        if (obs_idx !== exp_idx[c]) begin
          bad++;
          $display("FAIL stall_idx cyc=%0d got=%h want=%h", c, obs_idx, exp_idx[c]);
        end
      end
      if (c >= 3 && c <= 5) begin
        total++;
        if (obs_idx.k !== 4'd1 || obs_sig.mac !== 1'b0) begin
          bad++;
          $display("FAIL stall_hold cyc=%0d got k=%0d mac=%b want k=1 mac=0",
                   c, obs_idx.k, obs_sig.mac);
        end
      end
      if (obs_sig.done && first_done == 0) first_done = c;
    end
    total++;
    if (first_done != 24) begin
      bad++;
      $display("FAIL stall_latency got=%0d want=24", first_done);
    end
  endtask

  task automatic test_random();
    int first_done;
    for (int r = 0; r < 3; r++) begin
      sel = 1'b0;
      for (int n = 0; n < MAXC; n++) vld[n] = (n < 120) ? ($urandom_range(0, 3) != 0) : 1'b1;
      build(2, 2, 2, 1);
      for (int n = 1; n < last_c; n++) stv[n] = $urandom_range(0, 1) != 0;
      first_done = 0;
      start = 1'b1;
      for (int c = 1; c <= last_c; c++) begin
        step(c);
        total++;
        if (obs_sig !== exp_sig[c]) begin
          bad++;
          $display("FAIL rand_sig run=%0d cyc=%0d got=%b want=%b", r, c, obs_sig, exp_sig[c]);
        end
        if (exp_chk[c]) begin
          total++;
          if (obs_idx !== exp_idx[c]) begin
            bad++;
            $display("FAIL rand_idx run=%0d cyc=%0d got=%h want=%h", r, c, obs_idx, exp_idx[c]);
          end
        end
        if (obs_sig.done && first_done == 0) first_done = c;
      end
      total++;
      if (first_done != 21 + stalls) begin
        bad++;
        $display("FAIL rand_latency run=%0d got=%0d want=%0d", r, first_done, 21 + stalls);
      end
    end
  endtask

  task automatic test_abort();
    int first_done, stores, dones;
    sel = 1'b0;
    all_valid();
    build(2, 2, 2, 1);
    truncate(drain01_c);
    stores = 0;
    dones = 0;
    start = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      step(c);
      total++;
      if (obs_sig !== exp_sig[c]) begin
        bad++;
        $display("FAIL abort_sig cyc=%0d got=%b want=%b", c, obs_sig, exp_sig[c]);
      end
      if (exp_chk[c]) begin
        total++;
        if (obs_idx !== exp_idx[c]) begin
          bad++;
          $display("FAIL abort_idx cyc=%0d got=%h want=%h", c, obs_idx, exp_idx[c]);
        end
      end
      if (obs_sig.store) stores++;
      if (obs_sig.done) dones++;
    end
    total++;
    if (stores != 1 || dones != 0) begin
      bad++;
      $display("FAIL abort_effects got stores=%0d dones=%0d want 1/0", stores, dones);
    end
    // Restart with start and abort together in IDLE: start must win.
    build(2, 2, 2, 1);
    first_done = 0;
    start = 1'b1;
    abort = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      step(c);
      total++;
      if (obs_sig !== exp_sig[c]) begin
        bad++;
        $display("FAIL abort_rerun_sig cyc=%0d got=%b want=%b", c, obs_sig, exp_sig[c]);
      end
      if (obs_sig.done && first_done == 0) first_done = c;
    end
    total++;
    if (first_done != 21) begin
      bad++;
      $display("FAIL abort_rerun_latency got=%0d want=21", first_done);
    end
  endtask

  task automatic test_async_reset();
    int first_done;
    sel = 1'b0;
    all_valid();
    build(2, 2, 2, 1);
    start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step(c);
      total++;
      if (obs_sig !== exp_sig[c]) begin
        bad++;
        $display("FAIL areset_pre cyc=%0d got=%b want=%b", c, obs_sig, exp_sig[c]);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (obs_sig !== '0 || obs_idx !== '0) begin
      bad++;
      $display("FAIL areset_immediate got sig=%b idx=%h want 0", obs_sig, obs_idx);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    build(2, 2, 2, 1);
    first_done = 0;
    start = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      step(c);
      total++;
      if (obs_sig !== exp_sig[c]) begin
        bad++;
        $display("FAIL areset_rerun_sig cyc=%0d got=%b want=%b", c, obs_sig, exp_sig[c]);
      end
      if (obs_sig.done && first_done == 0) first_done = c;
    end
    total++;
    if (first_done != 21) begin
      bad++;
      $display("FAIL areset_rerun_latency got=%0d want=21", first_done);
    end
  endtask

  task automatic test_back_to_back();
    int first_done, gap;
    sel = 1'b0;
    all_valid();
    build(2, 2, 2, 1);
    for (int n = 1; n < MAXC; n++) stv[n] = 1'b1;
    start = 1'b1;
    for (int r = 0; r < 2; r++) begin
      if (r == 1) stv[last_c] = 1'b0;
      first_done = 0;
      gap = 0;
      for (int c = 1; c <= last_c; c++) begin
        step(c);
        total++;
        if (obs_sig !== exp_sig[c]) begin
          bad++;
          $display("FAIL b2b_sig run=%0d cyc=%0d got=%b want=%b", r, c, obs_sig, exp_sig[c]);
        end
        if (obs_sig.done && first_done == 0) first_done = c;
        if (first_done != 0 && !obs_sig.busy) gap++;
      end
      total++;
      if (first_done != 21 || gap != 1) begin
        bad++;
        $display("FAIL b2b_timing run=%0d got done=%0d idle=%0d want 21/1", r, first_done, gap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dims();
    test_stall();
    test_random();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
